// File: rtl/equilibrium_maxxing_uc.sv
// Session control unit for the pendulum balance game: calibrate, lock level, play ROUNDS rounds.
// Moore FSM, with outputs decoded from the state register and a registered fade tick.
module equilibrium_maxxing_uc #(
  parameter int unsigned ROUNDS      = 10,
  parameter int unsigned CAL_TIMEOUT = 50000000,
  parameter int unsigned FADE_DIV    = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       end_left,
  input  logic       end_right,
  input  logic       nivel_locked,
  input  logic       prep_done,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  output logic       calib,
  output logic       start_game,
  output logic       reset_prep_cnt,
  output logic       gerar_nova_jogada,
  output logic       conta_nivel,
  output logic       reset_nivel,
  output logic       reset_nivel_locked,
  output logic       fade_trigger,
  output logic       trava_servo,
  output logic       pronto,
  output logic       erro_calib,
  output logic [7:0] rodada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial  = 4'd0,
    StCalibra  = 4'd1,
    StSelNivel = 4'd2,
    StZeraPrep = 4'd3,
    StPrepara  = 4'd4,
    StGera     = 4'd5,
    StJogando  = 4'd6,
    StRegistra = 4'd7,
    StFim      = 4'd8,
    StErroCal  = 4'd9
  } state_e;

  localparam logic [31:0] CalLast  = 32'(CAL_TIMEOUT - 1);
  localparam logic [31:0] FadeLast = 32'(FADE_DIV - 1);
  localparam logic [7:0]  RoundsW  = 8'(ROUNDS);

  state_e      state_q, state_d;
  logic        iniciar_q;
  logic        ini_p;
  logic [31:0] cal_cnt_q, cal_cnt_d;
  logic [31:0] fade_cnt_q, fade_cnt_d;
  logic        fade_q, fade_d;
  logic [7:0]  rodada_q, rodada_d;
  logic [7:0]  rodada_inc;

  assign ini_p      = iniciar & ~iniciar_q;
  assign rodada_inc = (rodada_q == 8'hFF) ? rodada_q : rodada_q + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StInicial;
      iniciar_q  <= 1'b0;
      cal_cnt_q  <= '0;
      fade_cnt_q <= '0;
      fade_q     <= 1'b0;
      rodada_q   <= '0;
    end else begin
      state_q    <= state_d;
      iniciar_q  <= iniciar;
      cal_cnt_q  <= cal_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      fade_q     <= fade_d;
      rodada_q   <= rodada_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:  if (ini_p) state_d = StCalibra;
      StCalibra: begin
        // An end-stop on the timeout cycle still counts as a successful calibration.
        if (end_left | end_right)     state_d = StSelNivel;
        else if (cal_cnt_q == CalLast) state_d = StErroCal;
      end
      StSelNivel: if (nivel_locked) state_d = StZeraPrep;
      StZeraPrep: state_d = StPrepara;
      StPrepara:  if (prep_done) state_d = StGera;
      StGera:     state_d = StJogando;
      StJogando:  if (ganhou_ponto | perdeu_ponto) state_d = StRegistra;
      StRegistra: state_d = (rodada_inc == RoundsW) ? StFim : StZeraPrep;
      StFim:      if (ini_p) state_d = StInicial;
      StErroCal:  if (ini_p) state_d = StInicial;
      default:    state_d = StInicial;
    endcase
  end

  always_comb begin
    cal_cnt_d  = (state_q == StCalibra) ? cal_cnt_q + 32'd1 : '0;
    fade_cnt_d = '0;
    fade_d     = 1'b0;
    // Gated on staying in JOGANDO so the registered tick never leaks into REGISTRA.
    if (state_q == StJogando && state_d == StJogando) begin
      if (fade_cnt_q == FadeLast) begin
        fade_d = 1'b1;
      end else begin
        fade_cnt_d = fade_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    rodada_d = rodada_q;
    if (state_q == StInicial)       rodada_d = '0;
    else if (state_q == StRegistra) rodada_d = rodada_inc;
  end

  always_comb begin
    calib              = 1'b0;
    start_game         = 1'b0;
    reset_prep_cnt     = 1'b0;
    gerar_nova_jogada  = 1'b0;
    conta_nivel        = 1'b0;
    reset_nivel        = 1'b0;
    reset_nivel_locked = 1'b0;
    trava_servo        = 1'b0;
    pronto             = 1'b0;
    erro_calib         = 1'b0;
    case (state_q)
      StInicial: begin
        reset_nivel        = 1'b1;
        reset_nivel_locked = 1'b1;
        trava_servo        = 1'b1;
      end
      StCalibra:  calib             = 1'b1;
      StSelNivel: start_game        = 1'b1;
      StZeraPrep: reset_prep_cnt    = 1'b1;
      StPrepara:  trava_servo       = 1'b1;
      StGera:     gerar_nova_jogada = 1'b1;
      StRegistra: conta_nivel       = 1'b1;
      StFim: begin
        pronto      = 1'b1;
        trava_servo = 1'b1;
      end
      StErroCal: begin
        erro_calib  = 1'b1;
        trava_servo = 1'b1;
      end
      default: ;
    endcase
  end

  assign fade_trigger = fade_q;
  assign rodada       = rodada_q;
  assign db_estado    = state_q;

endmodule
